hbit_frame_acc: RTL and testbench
=================================

# hbit_frame_acc

Frame-level accumulator for high-bit counts. Sits directly downstream of the combinational `hbitcounter`: consumes one per-word popcount per accepted beat and sums it over a frame. A frame ends after `FRAME_LEN` words or on an early `in_last`. It then presents the frame's total, word count and majority flag on a registered valid/ready output.

## Interface
- `DATA_WIDTH`, 16: width of the counted word; legal `in_cnt` range is 0..`DATA_WIDTH`.
- `FRAME_LEN`, 64: maximum words per frame; must be ≥ 1.
- `CNT_W` (localparam) = `$clog2(DATA_WIDTH)+1`.
- `WRD_W` (localparam) = `$clog2(FRAME_LEN+1)`.
- `SUM_W` (localparam) = `$clog2(DATA_WIDTH*FRAME_LEN+1)`.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_cnt`/`in_last` valid.
- `in_ready`  out  1  block accepts the beat this cycle.
- `in_cnt`  in  `CNT_W`  popcount of one word, from `hbitcounter.dout`.
- `in_last`  in  1  accepted word closes the frame early.
- `out_valid`  out  1  frame result held.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  `SUM_W`  total high bits in the frame.
- `out_words`  out  `WRD_W`  words in the frame, 1..`FRAME_LEN`.
- `out_major`  out  1  `2*out_sum > out_words*DATA_WIDTH`.
- `out_err`  out  1  at least one `in_cnt > DATA_WIDTH` occurred in the frame.

## Operation
- States:
  - ACC: collecting a frame.
  - HOLD: result registered, `out_valid`=1.
- Accept = `in_valid && in_ready`.
- `in_ready = !rst && (state==ACC || out_ready)`. A new frame's first word may be accepted in the same cycle the held result is consumed.
- On accept:
  - `c = (in_cnt > DATA_WIDTH) ? DATA_WIDTH : in_cnt`, a clamp.
  - `acc_sum += c`, `acc_words += 1`.
  - `acc_err |= (in_cnt > DATA_WIDTH)`.
- Frame close: the accepted word has `in_last`=1, or `acc_words+1 == FRAME_LEN`. On close:
  - Final sum, words, err and major are loaded into the out registers.
  - State → HOLD.
  - Accumulators clear to 0.
- HOLD with `out_ready`=1: state → ACC unless the same cycle also accepts a closing word. In that case:
  - Out registers reload with the new frame.
  - State stays HOLD.
  - `out_valid` stays 1.
- HOLD with `out_ready`=1 and a non-closing accepted word: that word starts the new accumulation.
- Out registers change only on frame close. They are stable while `out_valid`=1 and `out_ready`=0.
- `out_major` is computed from the final frame values, with widths sized to `SUM_W+1` to avoid overflow.
- Arithmetic width:
  - `SUM_W` holds `DATA_WIDTH*FRAME_LEN` exactly, so no accumulator wrap is possible.
  - `acc_words` never exceeds `FRAME_LEN-1` in ACC.
- `in_last` on a non-accepted beat is ignored.
- `in_valid`=0 bubbles do not affect state.

## Timing
- Reset values:
  - state=ACC, `acc_sum`=0, `acc_words`=0, `acc_err`=0.
  - `out_valid`=0, `out_sum`=0, `out_words`=0, `out_major`=0, `out_err`=0.
  - `in_ready`=0 while `rst`=1, and 1 in the first cycle after.
- Latency: `out_valid` rises in the cycle after the edge that accepts the closing word (1 clock).
- Throughput: one word per cycle indefinitely when `out_ready` is held 1. This includes back-to-back 1-word frames (`in_last` on every beat), with `out_valid` continuously 1 and values updating every cycle.
- `rst` mid-frame or in HOLD: the partial frame and the held result are discarded. No `out_valid` pulse follows.
- `out_valid` deasserts only via handshake or reset.

## Test plan
- **Full frame:** `FRAME_LEN`=64, 64 beats `in_cnt`=3, no `in_last` → one result, `out_sum`=192, `out_words`=64, `out_major`=0, `out_err`=0, `out_valid` one cycle after beat 64.
- **Early close:** 5 beats `in_cnt`=16, `in_last` on beat 5 → `out_sum`=80, `out_words`=5, `out_major`=1. Follow with a 1-beat frame `in_cnt`=8 → `out_sum`=8, `out_words`=1, `out_major`=0 (equality is not a majority).
- **Backpressure:**
  - Hold `out_ready`=0 for 10 cycles after close → `out_*` stable, `in_ready`=0, beats with `in_valid`=1 not accepted.
  - Then `out_ready`=1 with `in_valid`=1, `in_cnt`=7 → handshake and new-frame accept in the same cycle, new frame starts with `acc_sum`=7.
- **Streaming 1-word frames:** `in_last`=1 and `out_ready`=1 every cycle with `in_cnt`=0,1,2,… → `out_valid` stays 1 and `out_sum` follows the input with 1-cycle delay, no lost beats.
- **Illegal input:** `in_cnt`=17 with `DATA_WIDTH`=16 in a 2-word frame with the other word `in_cnt`=4 → `out_sum`=20, `out_err`=1. The next clean frame shows `out_err`=0.
- **Reset mid-operation:**
  - `rst` after 30 beats of a frame → all outputs at reset values. The next 64 beats `in_cnt`=1 give `out_sum`=64, `out_words`=64.
  - `rst` in HOLD → `out_valid` falls the next cycle.

Source files
------------

// File: rtl/hbit_frame_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hbit_frame_acc : sums per-word popcounts over a frame, valid/ready result
// rev 1.0
// ---------------------------------------------------------------------------
module hbit_frame_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 64,
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1,
  localparam int WRD_W = $clog2(FRAME_LEN + 1),
  localparam int SUM_W = $clog2(DATA_WIDTH * FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [WRD_W-1:0] out_words,
  output logic             out_major,
  output logic             out_err
);

  localparam int MAJ_W = SUM_W + 1;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [SUM_W-1:0] acc_sum;
  logic [WRD_W-1:0] acc_words;
  logic             acc_err;

  logic             accept;
  logic             over;
  logic [CNT_W-1:0] clamped;
  logic [SUM_W-1:0] next_sum;
  logic [WRD_W-1:0] next_words;
  logic             next_err;
  logic             close;
  logic             next_major;

  assign in_ready   = !rst && (state == ACC || out_ready);
  assign accept     = in_valid && in_ready;
  assign over       = in_cnt > CNT_W'(DATA_WIDTH);
  assign clamped    = over ? CNT_W'(DATA_WIDTH) : in_cnt;
  assign next_sum   = acc_sum + SUM_W'(clamped);
  assign next_words = acc_words + WRD_W'(1);
  assign next_err   = acc_err | over;
  assign close      = accept && (in_last || next_words == WRD_W'(FRAME_LEN));
  // 2*sum versus words*DATA_WIDTH, both held in one extra bit so neither wraps
  assign next_major = {next_sum, 1'b0} > (MAJ_W'(next_words) * MAJ_W'(DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc_sum   <= '0;
      acc_words <= '0;
      acc_err   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_words <= '0;
      out_major <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (close) begin
        out_sum   <= next_sum;
        out_words <= next_words;
        out_major <= next_major;
        out_err   <= next_err;
        out_valid <= 1'b1;
        state     <= HOLD;
        acc_sum   <= '0;
        acc_words <= '0;
        acc_err   <= 1'b0;
      end else begin
        if (accept) begin
          acc_sum   <= next_sum;
          acc_words <= next_words;
          acc_err   <= next_err;
        end
        if (state == HOLD && out_ready) begin
          state     <= ACC;
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hbit_frame_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hbit_frame_acc : directed self-checking bench for hbit_frame_acc
// rev 1.0
// ---------------------------------------------------------------------------
module tb_hbit_frame_acc;

  localparam int DATA_WIDTH = 16;
  localparam int FRAME_LEN  = 64;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int WRD_W = $clog2(FRAME_LEN + 1);
  localparam int SUM_W = $clog2(DATA_WIDTH * FRAME_LEN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_cnt;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [WRD_W-1:0] out_words;
  logic             out_major;
  logic             out_err;

  int checks = 0;
  int errors = 0;

  hbit_frame_acc #(.DATA_WIDTH(DATA_WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cnt    (in_cnt),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_words (out_words),
    .out_major (out_major),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int s, input int w,
                         input int m, input int e);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sum"},   32'(out_sum),   32'(s));
    chk({tag, ".words"}, 32'(out_words), 32'(w));
    chk({tag, ".major"}, 32'(out_major), 32'(m));
    chk({tag, ".err"},   32'(out_err),   32'(e));
  endtask

  task automatic beat(input int cnt, input logic last);
    in_valid = 1'b1;
    in_cnt   = CNT_W'(cnt);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_cnt = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk_out("rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    // full 64-word frame, no in_last
    for (int i = 0; i < FRAME_LEN - 1; i++) beat(3, 1'b0);
    chk("full.pre_valid", 32'(out_valid), 32'd0);
    beat(3, 1'b0);
    chk_out("full", 1, 192, 64, 0, 0);
    consume();
    chk("full.consumed", 32'(out_valid), 32'd0);

    // early close and equality-is-not-majority
    for (int i = 0; i < 4; i++) beat(16, 1'b0);
    beat(16, 1'b1);
    chk_out("early", 1, 80, 5, 1, 0);
    consume();
    beat(8, 1'b1);
    chk_out("one8", 1, 8, 1, 0, 0);

    // backpressure: offered closing beats must be refused
    out_ready = 1'b0;
    in_valid = 1'b1; in_cnt = CNT_W'(5); in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.sum", 32'(out_sum), 32'd8);
      chk("bp.valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1; in_cnt = CNT_W'(7); in_last = 1'b0;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp.handshake", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    beat(2, 1'b1);
    chk_out("bp.newframe", 1, 9, 2, 0, 0);

    // streaming 1-word frames with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      beat(i, 1'b1);
      chk_out("stream", 1, i, 1, (2 * i > DATA_WIDTH) ? 1 : 0, 0);
    end
    consume();
    chk("stream.drain", 32'(out_valid), 32'd0);

    // illegal count, with a bubble carrying a stray in_last
    beat(17, 1'b0);
    in_valid = 1'b0; in_last = 1'b1;
    tick();
    in_last = 1'b0;
    chk("bubble.no_close", 32'(out_valid), 32'd0);
    beat(4, 1'b1);
    chk_out("illegal", 1, 20, 2, 1, 1);
    consume();
    beat(31, 1'b1);
    chk_out("clamp31", 1, 16, 1, 1, 1);
    consume();
    beat(4, 1'b1);
    chk_out("clean", 1, 4, 1, 0, 0);
    consume();

    // reset mid-frame discards the partial sum
    for (int i = 0; i < 30; i++) beat(1, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("midrst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk("midrst.no_pulse", 32'(out_valid), 32'd0);
    for (int i = 0; i < FRAME_LEN; i++) beat(1, 1'b0);
    chk_out("after_rst", 1, 64, 64, 0, 0);

    // reset while holding a result
    rst = 1'b1;
    tick();
    chk_out("holdrst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk("holdrst.stay_low", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
